// File: rtl/fp_pkg.sv
// Shared fixed-point helpers for accumulating sfp datapaths.
//   fp_mac_growth(n)    : integer bits an n-term sum adds on top of the product (0 for n=1)
//   fp_mac_widths_ok(..): 1 when an accumulator output has exactly the lossless width
//                         for the given operands and frame length
package fp_pkg;

   function automatic int fp_mac_growth(input int n);
      return (n <= 1) ? 0 : $clog2(n);
   endfunction

   function automatic bit fp_mac_widths_ok(input int out_iw, input int out_qw,
                                           input int iw1, input int qw1,
                                           input int iw2, input int qw2,
                                           input int nacc);
      return (out_iw == iw1 + iw2 + fp_mac_growth(nacc)) && (out_qw == qw1 + qw2);
   endfunction

endpackage

// File: rtl/sfp_mac_full_if.sv
// sfp: signed fixed-point word with iw integer bits and qw fraction bits.
//   val : two's complement value, real value = val * 2^-qw
//   modport in  : consumer side
//   modport out : producer side
interface sfp #(
   parameter int iw = 1,
   parameter int qw = 0
);
   logic signed [iw+qw-1:0] val;

   modport in  (input  val);
   modport out (output val);
endinterface

// File: rtl/sfp_mult_full.sv
// Full-precision combinational signed fixed-point multiplier.
//   in1, in2 : sfp operands
//   out      : sfp product, width in1+in2 (integer and fraction bits add)
module sfp_mult_full (
   sfp.in  in1,
   sfp.in  in2,
   sfp.out out
);
   localparam int W1 = in1.iw + in1.qw;
   localparam int W2 = in2.iw + in2.qw;
   localparam int W  = W1 + W2;

   // Sign-extend both operands to the product width so the multiply is
   // evaluated signed at full width.
   logic signed [W-1:0] a, b;

   assign a       = W'(in1.val);
   assign b       = W'(in2.val);
   assign out.val = a * b;
endmodule

// File: rtl/sfp_mac_full.sv
// Pipelined full-precision signed fixed-point multiply-accumulate.
// Sums frames of up to NACC products without rounding or overflow.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous flush of the partial frame and product stage
//   in1, in2   : sfp operands; in_valid/in_ready handshake, in_last closes a frame
//   out        : sfp frame sum; out_valid/out_ready handshake
// Parameters: NACC (max products per frame), PIPE_MULT (register the product).
module sfp_mac_full
   import fp_pkg::*;
#(
   parameter int NACC      = 4,
   parameter bit PIPE_MULT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   sfp.in       in1,
   sfp.in       in2,
   input  logic in_valid,
   input  logic in_last,
   output logic in_ready,
   sfp.out      out,
   output logic out_valid,
   input  logic out_ready
);
   localparam int IW1 = in1.iw;
   localparam int QW1 = in1.qw;
   localparam int IW2 = in2.iw;
   localparam int QW2 = in2.qw;
   localparam int PIW = IW1 + IW2;
   localparam int PQW = QW1 + QW2;
   localparam int PW  = PIW + PQW;
   localparam int OW  = out.iw + out.qw;
   localparam int CW  = (NACC > 1) ? $clog2(NACC) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(NACC - 1);

   if (!fp_mac_widths_ok(out.iw, out.qw, IW1, QW1, IW2, QW2, NACC)) begin : g_width_err
      $error("sfp_mac_full: out must be iw=%0d qw=%0d",
             IW1 + IW2 + fp_mac_growth(NACC), QW1 + QW2);
   end

   // Full-width product
   sfp #(.iw(PIW), .qw(PQW)) prod ();

   sfp_mult_full u_mult (
      .in1 (in1),
      .in2 (in2),
      .out (prod)
   );

   // Handshake: the whole pipe freezes while a finished sum waits.
   logic stall, accept;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;

   // Stage 1: product feeding the accumulator
   logic signed [PW-1:0] s1_prod;
   logic                 s1_last;
   logic                 s1_vld;

   if (PIPE_MULT) begin : g_pipe
      logic signed [PW-1:0] p_reg;
      logic                 p_last;
      logic                 p_vld;

      // clr drops both the held product and a beat arriving with it.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            p_reg  <= '0;
            p_last <= 1'b0;
            p_vld  <= 1'b0;
         end else if (clr) begin
            p_vld  <= 1'b0;
         end else if (accept) begin
            p_reg  <= prod.val;
            p_last <= in_last;
            p_vld  <= 1'b1;
         end else if (!stall) begin
            p_vld  <= 1'b0;
         end
      end

      assign s1_prod = p_reg;
      assign s1_last = p_last;
      assign s1_vld  = p_vld;
   end else begin : g_comb
      assign s1_prod = prod.val;
      assign s1_last = in_last;
      assign s1_vld  = accept;
   end

   // Stage 2: accumulate
   logic [CW-1:0]        cnt;
   logic signed [OW-1:0] acc, acc_next, prod_ext;
   logic                 fire, close;

   assign prod_ext = OW'(s1_prod);
   assign fire     = s1_vld && !stall && !clr;
   // First beat of a frame loads instead of adding, so frames run back to back.
   assign acc_next = (cnt == '0) ? prod_ext : acc + prod_ext;
   assign close    = (cnt == CNT_MAX) || s1_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         out.val   <= '0;
         out_valid <= 1'b0;
      end else begin
         if (clr) begin
            cnt <= '0;
         end else if (fire) begin
            acc <= acc_next;
            cnt <= close ? '0 : cnt + CW'(1);
         end

         // A sum completing while the previous one drains replaces it.
         if (fire && close) begin
            out.val   <= acc_next;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule
